// File: rtl/snn_pkg.sv
// Shared types and defaults for spike-domain blocks (encoder, neurons, future decoder).
package snn_pkg;

  localparam int DEF_MAG_W  = 4;
  localparam int DEF_WINDOW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Spike pair as seen on a neuron's data_in/sign_in inputs
  typedef struct packed {
    logic data;
    logic sign;
  } spike_t;

endpackage

// File: rtl/spike_accum.sv
// Purpose: one error-accumulation step that spreads mag spikes evenly over WINDOW slots.
// Latency: combinational.
// Backpressure: none, pure function of acc and mag.
module spike_accum #(
  parameter int MAG_W  = 4,
  parameter int WINDOW = 16,
  parameter int AW     = $clog2(WINDOW) + 1
) (
  input  logic [AW-1:0]    acc,
  input  logic [MAG_W-1:0] mag,
  output logic [AW-1:0]    next_acc,
  output logic             spike
);

  logic [AW-1:0] sum;

  // acc < WINDOW and mag < WINDOW, so the sum stays below 2*WINDOW and fits in AW bits
  assign sum      = acc + AW'(mag);
  assign spike    = (sum >= AW'(WINDOW));
  assign next_acc = spike ? (sum - AW'(WINDOW)) : sum;

endmodule

// File: rtl/spike_encoder.sv
// Purpose: rate-codes one signed-magnitude value into |value| evenly spread spikes over WINDOW slots.
// Latency: slot 1 appears one cycle after the accept edge; done marks slot WINDOW.
// Backpressure: in_ready high only in IDLE; in_valid is ignored for the whole window.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int MAG_W  = DEF_MAG_W,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_sign,
  output logic             data_out,
  output logic             sign_out,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(WINDOW) + 1;
  localparam int CW = $clog2(WINDOW);

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic             sign_q, sign_d;
  spike_t           out_q, out_d;
  logic             done_q, done_d;

  logic [AW-1:0]    step_acc;
  logic             step_spike;

  spike_accum #(
    .MAG_W  (MAG_W),
    .WINDOW (WINDOW),
    .AW     (AW)
  ) u_accum (
    .acc      (acc_q),
    .mag      (mag_q),
    .next_acc (step_acc),
    .spike    (step_spike)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    out_d   = '0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_d   = in_mag;
          sign_d  = in_sign;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d      = step_acc;
        out_d.data = step_spike;
        out_d.sign = step_spike & sign_q;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(WINDOW - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == RUN);
  assign data_out = out_q.data;
  assign sign_out = out_q.sign;
  assign done     = done_q;

endmodule
